// File: rtl/cp0_int_ctrl_if.sv
// CP0 write-port bundle: CPU-side MTC0 request and the arbitrated CP0 write port.
interface cp0_int_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             cpu_we;
    logic [4:0]       cpu_waddr;
    logic [2:0]       cpu_sel;
    logic [WIDTH-1:0] cpu_din;
    logic             cp0_we;
    logic [4:0]       cp0_waddr;
    logic [2:0]       cp0_sel;
    logic [WIDTH-1:0] cp0_din;

    modport master (
        output cpu_we, cpu_waddr, cpu_sel, cpu_din,
        input  cp0_we, cp0_waddr, cp0_sel, cp0_din
    );

    modport slave (
        input  cpu_we, cpu_waddr, cpu_sel, cpu_din,
        output cp0_we, cp0_waddr, cp0_sel, cp0_din
    );
endinterface

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller: saves EPC/Cause, vectors to the handler and returns on ERET.
// Optional macro CP0_IRQ_MASK_EN adds an irq mask register at CP0 reg 12, sel 0.
module cp0_int_ctrl #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] VECTOR_BASE = 32'h0000_3000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [2:0]       irq,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             eret,
    cp0_int_ctrl_if.slave    bus,
    output logic             stall,
    output logic             pc_redirect,
    output logic [WIDTH-1:0] pc_target,
    output logic             in_service
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE    = 3'd1,
        CAUSE   = 3'd2,
        JUMP    = 3'd3,
        SERVICE = 3'd4,
        RETURN  = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [1:0]       id_r;
    logic [1:0]       id_nxt_s;
    logic [WIDTH-1:0] epc_r;
    logic [WIDTH-1:0] epc_nxt_s;
    logic [2:0]       irq_en_s;

    function automatic logic [1:0] irq_prio(input logic [2:0] req);
        logic [1:0] idx;
        if (req[2]) begin
            idx = 2'd2;
        end else if (req[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

`ifdef CP0_IRQ_MASK_EN
    logic [2:0] mask_r;
    logic       mask_load_s;

    // Only writes actually forwarded to CP0 may load the mask
    assign mask_load_s = bus.cpu_we && !clr
                         && ((state_r == IDLE) || (state_r == SERVICE))
                         && (bus.cpu_waddr == 5'd12) && (bus.cpu_sel == 3'd0);

    // Interrupt mask register
    always_ff @(posedge clk) begin
        if (clr) begin
            mask_r <= 3'b111;
        end else if (mask_load_s) begin
            mask_r <= bus.cpu_din[2:0];
        end else begin
            mask_r <= mask_r;
        end
    end

    assign irq_en_s = irq & mask_r;
`else
    assign irq_en_s = irq;
`endif

    // State, latched id and latched return address
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= IDLE;
            id_r    <= 2'd0;
            epc_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            id_r    <= id_nxt_s;
            epc_r   <= epc_nxt_s;
        end
    end

    // Next-state decode, CP0 port arbitration and PC redirect
    always_comb begin
        state_nxt_s   = state_r;
        id_nxt_s      = id_r;
        epc_nxt_s     = epc_r;
        bus.cp0_we    = bus.cpu_we;
        bus.cp0_waddr = bus.cpu_waddr;
        bus.cp0_sel   = bus.cpu_sel;
        bus.cp0_din   = bus.cpu_din;
        stall         = 1'b0;
        pc_redirect   = 1'b0;
        pc_target     = '0;
        in_service    = 1'b0;
        // Reset behaves as IDLE on the outputs so an aborted sequence writes nothing
        if (clr) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|irq_en_s) begin
                        state_nxt_s = SAVE;
                        id_nxt_s    = irq_prio(irq_en_s);
                        epc_nxt_s   = pc_in;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                SAVE: begin
                    bus.cp0_we    = 1'b1;
                    bus.cp0_waddr = 5'd14;
                    bus.cp0_sel   = 3'd0;
                    bus.cp0_din   = epc_r;
                    stall         = 1'b1;
                    state_nxt_s   = CAUSE;
                end
                CAUSE: begin
                    bus.cp0_we    = 1'b1;
                    bus.cp0_waddr = 5'd13;
                    bus.cp0_sel   = 3'd0;
                    bus.cp0_din   = {{(WIDTH-5){1'b0}}, 1'b1, id_r, 2'b00};
                    stall         = 1'b1;
                    state_nxt_s   = JUMP;
                end
                JUMP: begin
                    bus.cp0_we    = 1'b0;
                    bus.cp0_waddr = 5'd0;
                    bus.cp0_sel   = 3'd0;
                    bus.cp0_din   = '0;
                    stall         = 1'b1;
                    pc_redirect   = 1'b1;
                    pc_target     = VECTOR_BASE + {{(WIDTH-6){1'b0}}, id_r, 4'b0000};
                    state_nxt_s   = SERVICE;
                end
                SERVICE: begin
                    in_service = 1'b1;
                    if (eret) begin
                        state_nxt_s = RETURN;
                    end else begin
                        state_nxt_s = SERVICE;
                    end
                end
                RETURN: begin
                    bus.cp0_we    = 1'b1;
                    bus.cp0_waddr = 5'd13;
                    bus.cp0_sel   = 3'd0;
                    bus.cp0_din   = '0;
                    stall         = 1'b1;
                    pc_redirect   = 1'b1;
                    pc_target     = epc_r;
                    state_nxt_s   = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed bench for cp0_int_ctrl: interrupt entry, ERET return, forwarding, reset abort, optional mask.
module tb_cp0_int_ctrl;

    logic        clk;
    logic        clr;
    logic [2:0]  irq;
    logic [31:0] pc_in;
    logic        eret;
    logic        stall;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        in_service;
    int          err_cnt;
    int          chk_cnt;

    cp0_int_ctrl_if #(.WIDTH(32)) bus ();

    cp0_int_ctrl #(.WIDTH(32), .VECTOR_BASE(32'h0000_3000)) dut (
        .clk         (clk),
        .clr         (clr),
        .irq         (irq),
        .pc_in       (pc_in),
        .eret        (eret),
        .bus         (bus),
        .stall       (stall),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .in_service  (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.cpu_we    = we;
        bus.cpu_waddr = a;
        bus.cpu_sel   = 3'd0;
        bus.cpu_din   = d;
    endtask

    task automatic check_ctl(input string tag, input logic st, input logic rd, input logic sv);
        check_eq({tag, "_stall"}, {31'd0, stall}, {31'd0, st});
        check_eq({tag, "_redir"}, {31'd0, pc_redirect}, {31'd0, rd});
        check_eq({tag, "_insvc"}, {31'd0, in_service}, {31'd0, sv});
    endtask

    task automatic check_cp0(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        check_eq({tag, "_we"}, {31'd0, bus.cp0_we}, {31'd0, we});
        if (we) begin
            check_eq({tag, "_waddr"}, {27'd0, bus.cp0_waddr}, {27'd0, a});
            check_eq({tag, "_din"}, bus.cp0_din, d);
        end else begin
            check_eq({tag, "_nowe"}, {31'd0, bus.cp0_we}, 32'd0);
        end
    endtask

    // full entry sequence from IDLE; irq drops after being latched
    task automatic enter(input string tag, input logic [2:0] req, input logic [31:0] pc,
                         input logic [31:0] cause, input logic [31:0] tgt);
        irq   = req;
        pc_in = pc;
        #1;
        check_ctl({tag, "_idle"}, 1'b0, 1'b0, 1'b0);
        cyc();
        irq = 3'b000;
        #1;
        check_cp0({tag, "_save"}, 1'b1, 5'd14, pc);
        check_ctl({tag, "_save"}, 1'b1, 1'b0, 1'b0);
        cyc();
        check_cp0({tag, "_cause"}, 1'b1, 5'd13, cause);
        check_ctl({tag, "_cause"}, 1'b1, 1'b0, 1'b0);
        cyc();
        check_ctl({tag, "_jump"}, 1'b1, 1'b1, 1'b0);
        check_eq({tag, "_target"}, pc_target, tgt);
        cyc();
        check_ctl({tag, "_svc"}, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic leave(input string tag, input logic [31:0] epc);
        eret = 1'b1;
        cyc();
        eret = 1'b0;
        #1;
        check_cp0({tag, "_ret"}, 1'b1, 5'd13, 32'd0);
        check_ctl({tag, "_ret"}, 1'b1, 1'b1, 1'b0);
        check_eq({tag, "_ret_target"}, pc_target, epc);
        cyc();
        check_ctl({tag, "_back"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        clr     = 1'b1;
        irq     = 3'b000;
        pc_in   = 32'd0;
        eret    = 1'b0;
        cpu_wr(1'b0, 5'd0, 32'd0);
        cyc();
        cyc();

        // reset: outputs idle, CP0 port mirrors the CPU
        cpu_wr(1'b1, 5'd3, 32'h0000_00ab);
        #1;
        check_ctl("rst", 1'b0, 1'b0, 1'b0);
        check_eq("rst_target", pc_target, 32'd0);
        check_cp0("rst_mirror", 1'b1, 5'd3, 32'h0000_00ab);
        cyc();
        clr = 1'b0;
        cpu_wr(1'b0, 5'd0, 32'd0);
        cyc();

        // irq with concurrent CPU write: write forwarded now, held write blocked later
        cpu_wr(1'b1, 5'd12, 32'h0000_0005);
        irq   = 3'b010;
        pc_in = 32'h0000_0040;
        #1;
        check_cp0("fwd_idle", 1'b1, 5'd12, 32'h0000_0005);
        check_ctl("fwd_idle", 1'b0, 1'b0, 1'b0);
        cyc();
        irq = 3'b000;
        #1;
        check_cp0("t1_save", 1'b1, 5'd14, 32'h0000_0040);
        check_ctl("t1_save", 1'b1, 1'b0, 1'b0);
        cyc();
        check_cp0("t1_cause", 1'b1, 5'd13, 32'h0000_0014);
        check_ctl("t1_cause", 1'b1, 1'b0, 1'b0);
        cyc();
        check_ctl("t1_jump", 1'b1, 1'b1, 1'b0);
        check_eq("t1_target", pc_target, 32'h0000_3010);
        check_cp0("t1_jump", 1'b0, 5'd0, 32'd0);
        cyc();
        cpu_wr(1'b1, 5'd9, 32'h0000_0077);
        irq = 3'b111;
        #1;
        check_ctl("t1_svc", 1'b0, 1'b0, 1'b1);
        check_cp0("svc_mirror", 1'b1, 5'd9, 32'h0000_0077);
        cyc();
        cpu_wr(1'b0, 5'd0, 32'd0);
        #1;
        check_ctl("t1_svc_nonest", 1'b0, 1'b0, 1'b1);
        irq = 3'b000;
        leave("t1", 32'h0000_0040);

        // eret outside SERVICE has no effect
        eret = 1'b1;
        #1;
        check_ctl("eret_idle", 1'b0, 1'b0, 1'b0);
        check_cp0("eret_idle", 1'b0, 5'd0, 32'd0);
        cyc();
        eret = 1'b0;
        #1;
        check_ctl("eret_idle2", 1'b0, 1'b0, 1'b0);

        // highest-priority selection
        enter("t2", 3'b101, 32'h0000_0100, 32'h0000_0018, 32'h0000_3020);
        leave("t2", 32'h0000_0100);

        // lowest line alone
        enter("t3", 3'b001, 32'h0000_0204, 32'h0000_0010, 32'h0000_3000);
        leave("t3", 32'h0000_0204);

        // clr in CAUSE aborts the sequence
        irq   = 3'b100;
        pc_in = 32'h0000_0200;
        cyc();
        irq = 3'b000;
        cyc();
        clr = 1'b1;
        cpu_wr(1'b1, 5'd7, 32'h0000_0033);
        #1;
        check_ctl("clr_cause", 1'b0, 1'b0, 1'b0);
        check_cp0("clr_cause", 1'b1, 5'd7, 32'h0000_0033);
        cyc();
        clr = 1'b0;
        #1;
        check_ctl("clr_after", 1'b0, 1'b0, 1'b0);
        check_cp0("clr_after", 1'b1, 5'd7, 32'h0000_0033);
        cyc();
        cpu_wr(1'b0, 5'd0, 32'd0);
        #1;
        check_ctl("clr_after2", 1'b0, 1'b0, 1'b0);

        // clr overrides irq in IDLE
        clr = 1'b1;
        irq = 3'b111;
        cyc();
        clr = 1'b0;
        irq = 3'b000;
        #1;
        check_ctl("clr_irq", 1'b0, 1'b0, 1'b0);
        cyc();
        check_ctl("clr_irq2", 1'b0, 1'b0, 1'b0);

`ifdef CP0_IRQ_MASK_EN
        // masked line ignored, enabled line taken
        cpu_wr(1'b1, 5'd12, 32'h0000_0001);
        cyc();
        cpu_wr(1'b0, 5'd0, 32'd0);
        irq = 3'b100;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_ctl("mask_blk", 1'b0, 1'b0, 1'b0);
        end
        enter("mask", 3'b101, 32'h0000_0300, 32'h0000_0010, 32'h0000_3000);
        leave("mask", 32'h0000_0300);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/cp0_int_ctrl.md
CP0_INT_CTRL -- requirements
Module: cp0_int_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: data and PC width.
REQ-002 Parameter VECTOR_BASE, default 32'h0000_3000: handler vector base.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 clr  input  1  synchronous, active-high reset.
REQ-005 irq  input  3  level interrupt requests; irq[2] highest priority, irq[0] lowest.
REQ-006 pc_in  input  WIDTH  return address of the instruction being interrupted.
REQ-007 eret  input  1  one-cycle pulse: ERET retiring.
REQ-008 cpu_we / cpu_waddr / cpu_sel / cpu_din  input  1/5/3/WIDTH  MTC0 write request from the CPU.
REQ-009 cp0_we / cp0_waddr / cp0_sel / cp0_din  output  1/5/3/WIDTH  arbitrated CP0 write port.
REQ-010 stall  output  1  freezes the CPU pipeline while the controller owns CP0 or redirects the PC.
REQ-011 pc_redirect  output  1  one-cycle pulse: load pc_target into the PC.
REQ-012 pc_target  output  WIDTH  redirect address.
REQ-013 in_service  output  1  high while a handler is running.

Function
REQ-014 FSM states: IDLE, SAVE, CAUSE, JUMP, SERVICE, RETURN.
REQ-015 IDLE: any enabled irq bit -> latch id = index of the highest-priority set bit and latch epc = pc_in -> SAVE next cycle.
REQ-016 SAVE: cp0_we=1, waddr=14, sel=0, din=epc -> CAUSE.
REQ-017 CAUSE: cp0_we=1, waddr=13, sel=0, din={zeros, 1'b1, id[1:0], 2'b00} (bit 4 = pending flag, bits 3:2 = id) -> JUMP.
REQ-018 JUMP: pc_redirect=1, pc_target = VECTOR_BASE + (id << 4) -> SERVICE.
REQ-019 SERVICE: in_service=1; irq ignored (no nesting); eret=1 -> RETURN.
REQ-020 RETURN: cp0_we=1, waddr=13, sel=0, din=0; pc_redirect=1, pc_target=epc -> IDLE.
REQ-021 stall=1 in SAVE, CAUSE, JUMP and RETURN; stall=0 in IDLE and SERVICE.
REQ-022 In IDLE and SERVICE, cp0_* outputs combinationally mirror cpu_*; in the other states, the controller drives the port and cpu_we is dropped (the CPU is stalled, so it holds the request).
REQ-023 IDLE with irq and cpu_we in the same cycle: the CPU write passes through that cycle; the FSM enters SAVE on the next cycle.
REQ-024 eret outside SERVICE is ignored with no output effect.
REQ-025 A request that drops after being latched in IDLE still completes the full sequence using the latched id.
REQ-026 Interrupt-entry latency: irq sampled in cycle N -> pc_redirect pulses in cycle N+3.

Reset
REQ-027 clr=1 at posedge: state=IDLE, id=0, epc=0, mask=3'b111.
REQ-028 During and after reset until the next event: all outputs 0, except cp0_* which mirror cpu_*.
REQ-029 clr in any state, including mid-sequence, aborts with no redirect and no further controller CP0 writes; clr overrides irq and eret in the same cycle.

Configuration
REQ-030 Macro CP0_IRQ_MASK_EN defined: a 3-bit mask register is loaded from cpu_din[2:0] when a forwarded CPU write targets waddr=12, sel=0; irq is ANDed with the mask before priority selection.
REQ-031 CP0_IRQ_MASK_EN undefined: no mask register exists; all irq lines are always enabled.

Verification
REQ-032 irq=3'b010, pc_in=32'h0000_0040 in IDLE -> writes reg14=32'h40, then reg13=32'h14; pc_redirect with pc_target=32'h0000_3010 at N+3; stall high for 3 cycles.
REQ-033 irq=3'b101 -> id=2, CAUSE din=32'h18, pc_target=32'h0000_3020.
REQ-034 In SERVICE, pulse eret with epc=32'h40 -> reg13 written 0, pc_redirect with pc_target=32'h40, state IDLE; a new irq during SERVICE is ignored.
REQ-035 cpu_we=1, waddr=12, din=32'h5 concurrent with irq in IDLE -> CPU write forwarded that cycle; SAVE follows; CPU write during CAUSE is not forwarded.
REQ-036 clr asserted in CAUSE -> next cycle IDLE, no pc_redirect, cp0_we = cpu_we.
REQ-037 With CP0_IRQ_MASK_EN: write mask=3'b001, then raise irq=3'b100 -> no response; then raise irq=3'b101 -> id=0, pc_target=32'h0000_3000.
